// File: rtl/inst_fetch_cache_pkg.sv
// Shared sizes, FSM states and word-select helper for the
// instruction fetch cache.
package inst_fetch_cache_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int BLOCK_SIZE  = 512;
    localparam int BYTE_SIZE   = 8;
    localparam int BLOCK_BYTES = BLOCK_SIZE / BYTE_SIZE;
    localparam int WORD_BYTES  = WORD_SIZE / BYTE_SIZE;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int WB_W        = $clog2(WORD_BYTES);
    localparam int WSEL_W      = OFF_W - WB_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_WAIT
    } state_e;

    // Lowest-addressed word sits in the most significant bits.
    function automatic logic [WORD_SIZE-1:0] word_sel(
        input logic [BLOCK_SIZE-1:0] blk,
        input logic [WSEL_W-1:0]     k
    );
        return blk[BLOCK_SIZE-1-(int'(k)*WORD_SIZE) -: WORD_SIZE];
    endfunction

endpackage

// File: rtl/inst_fetch_cache_icache_array.sv
// Direct-mapped tag/valid/data store: one combinational read port,
// a paired even/odd line write port and a synchronous clear.
module icache_array
    import inst_fetch_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 22,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [BLOCK_SIZE-1:0] rd_data_o,
    input  logic                  we_i,
    input  logic [IDX_W-2:0]      wr_pair_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [BLOCK_SIZE-1:0] wr_even_i,
    input  logic [BLOCK_SIZE-1:0] wr_odd_i
);

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [BLOCK_SIZE-1:0] data_q [LINES];
    logic [IDX_W-1:0]      ev_idx;
    logic [IDX_W-1:0]      od_idx;

    assign ev_idx     = {wr_pair_i, 1'b0};
    assign od_idx     = {wr_pair_i, 1'b1};
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Valid bits: a clear outranks a simultaneous line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[ev_idx] <= 1'b1;
            valid_q[od_idx] <= 1'b1;
        end
    end

    // Tag and data storage is never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[ev_idx]  <= wr_tag_i;
            tag_q[od_idx]  <= wr_tag_i;
            data_q[ev_idx] <= wr_even_i;
            data_q[od_idx] <= wr_odd_i;
        end
    end

endmodule

// File: rtl/inst_fetch_cache.sv
// Blocking instruction fetch cache: one request in flight,
// misses refill an even/odd block pair from instruction memory.
module inst_fetch_cache
    import inst_fetch_cache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [WORD_SIZE-1:0]  req_addr,
    output logic                  req_ready,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [WORD_SIZE-1:0]  resp_inst,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic                  mem_readable,
    output logic                  mem_writable,
    output logic [BLOCK_SIZE-1:0] mem_write,
    input  logic [BLOCK_SIZE-1:0] mem_out1,
    input  logic [BLOCK_SIZE-1:0] mem_out2,
    output logic [15:0]           miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

    state_e                state_q, state_d;
    logic [WORD_SIZE-1:0]  addr_q;
    logic                  resp_valid_q;
    logic [WORD_SIZE-1:0]  resp_inst_q;
    logic [15:0]           miss_q;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_SIZE-1:0] rd_data;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     k;
    logic                  hit;
    logic                  fill;
    logic                  resp_set;
    logic                  miss_inc;
    logic [WORD_SIZE-1:0]  resp_word;
    logic                  unused_lsb;

    assign tag        = addr_q[WORD_SIZE-1 -: TAG_W];
    assign k          = addr_q[OFF_W-1:WB_W];
    assign hit        = rd_valid && (rd_tag == tag);
    assign unused_lsb = ^addr_q[WB_W-1:0];

    assign resp_valid   = resp_valid_q;
    assign resp_inst    = resp_inst_q;
    assign miss_count   = miss_q;
    assign mem_writable = 1'b0;
    assign mem_write    = '0;

    icache_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (flush),
        .rd_idx_i   (addr_q[OFF_W +: IDX_W]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill),
        .wr_pair_i  (addr_q[OFF_W+1 +: IDX_W-1]),
        .wr_tag_i   (tag),
        .wr_even_i  (mem_out1),
        .wr_odd_i   (mem_out2)
    );

    // Next state, handshake, memory strobe and response selection.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        mem_readable = 1'b0;
        mem_addr     = '0;
        fill         = 1'b0;
        resp_set     = 1'b0;
        miss_inc     = 1'b0;
        resp_word    = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_set  = 1'b1;
                    resp_word = word_sel(rd_data, k);
                    state_d   = S_IDLE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                mem_readable = 1'b1;
                mem_addr     = {addr_q[WORD_SIZE-1:OFF_W+1],
                                {(OFF_W+1){1'b0}}};
                state_d      = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                fill      = 1'b1;
                resp_set  = 1'b1;
                resp_word = word_sel(addr_q[OFF_W] ? mem_out2
                                                   : mem_out1, k);
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched address, response pulse and miss counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_set;
            if (state_q == S_IDLE && req_valid) addr_q <= req_addr;
            if (resp_set) resp_inst_q <= resp_word;
            if (miss_inc && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Scoreboard bench for inst_fetch_cache with a block-level
// reference model and a byte-addressed instruction memory model.
module tb_inst_fetch_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         req_ready;
    logic         flush = 1'b0;
    logic         resp_valid;
    logic [31:0]  resp_inst;
    logic [31:0]  mem_addr;
    logic         mem_readable;
    logic         mem_writable;
    logic [511:0] mem_write;
    logic [511:0] mem_out1 = '0;
    logic [511:0] mem_out2 = '0;
    logic [15:0]  miss_count;

    inst_fetch_cache #(.LINES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_inst    (resp_inst),
        .mem_addr     (mem_addr),
        .mem_readable (mem_readable),
        .mem_writable (mem_writable),
        .mem_write    (mem_write),
        .mem_out1     (mem_out1),
        .mem_out2     (mem_out2),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] inst;
        int          due;
        logic [31:0] addr;
    } exp_t;

    exp_t        rq[$];
    logic [31:0] mq[$];

    // Reference model: per line, which block number it holds.
    bit mv[16];
    int mblk[16];
    int mmiss = 0;

    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd37 + (a >> 8) * 32'd11 + 32'd5;
        return t[7:0];
    endfunction

    function automatic logic [511:0] blk(input logic [31:0] base);
        logic [511:0] b;
        for (int j = 0; j < 64; j++) b[511-8*j -: 8] = mb(base + j);
        return b;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return {mb(w), mb(w + 1), mb(w + 2), mb(w + 3)};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endfunction

    // Model one accepted request at accept edge number acc.
    function automatic void model_access(input logic [31:0] a,
                                         input int acc);
        int bn, pb;
        bit hit;
        exp_t e;
        bn  = int'(a >> 6);
        hit = mv[bn % 16] && mblk[bn % 16] == bn;
        if (!hit) begin
            if (mmiss < 65535) mmiss++;
            pb = (bn / 2) * 2;
            mv[pb % 16]       = 1'b1;
            mblk[pb % 16]     = pb;
            mv[(pb + 1) % 16]   = 1'b1;
            mblk[(pb + 1) % 16] = pb + 1;
            mq.push_back(32'(pb) << 6);
        end
        // Seen at the falling edge before edge acc+2 (hit) / acc+4 (miss).
        e.inst = word(a);
        e.due  = acc + (hit ? 1 : 3);
        e.addr = a;
        rq.push_back(e);
    endfunction

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    // Instruction memory: pair data appears the cycle after the read edge.
    logic [31:0] pa;
    always @(posedge clk) begin
        if (rst_n && mem_readable) begin
            pa = mem_addr;
            #1;
            mem_out1 = blk(pa);
            mem_out2 = blk(pa + 32'd64);
            #10;
            mem_out1 = {16{$urandom}};
            mem_out2 = {16{$urandom}};
        end
    end

    // Monitor: pops expectations whenever the DUT presents something.
    exp_t        me;
    logic [31:0] ma;
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got=%h", resp_inst);
                end else begin
                    me = rq.pop_front();
                    if (resp_inst !== me.inst || cyc != me.due) begin
                        errors++;
                        $display("FAIL resp addr=%h got=%h@%0d exp=%h@%0d",
                                 me.addr, resp_inst, cyc, me.inst, me.due);
                    end
                end
            end
            checks++;
            if (mem_readable) begin
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL mem_read_unexpected got=%h", mem_addr);
                end else begin
                    ma = mq.pop_front();
                    if (mem_addr !== ma) begin
                        errors++;
                        $display("FAIL mem_addr got=%h exp=%h", mem_addr, ma);
                    end
                end
            end else if (mem_addr !== 32'd0 || mem_writable !== 1'b0 ||
                         mem_write !== '0) begin
                errors++;
                $display("FAIL mem_idle got=%h exp=0", mem_addr);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input bit keep);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout got=0 exp=1");
        end
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1;
        model_access(a, cyc);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || mq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rq.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0", rq.size());
            rq.delete();
            mq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_inst", resp_inst, 0);
        chk("rst_mem_readable", 32'(mem_readable), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_miss_count", 32'(miss_count), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h104, 0);
        drain();
        chk("miss_first", 32'(miss_count), 32'(mmiss));

        issue(32'h148, 0);
        drain();
        chk("hit_pair_odd", 32'(miss_count), 1);

        issue(32'h504, 0);
        issue(32'h104, 0);
        drain();
        chk("conflict", 32'(miss_count), 3);

        issue(32'h200, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        drain();
        issue(32'h200, 0);
        drain();
        chk("flush_remiss", 32'(miss_count), 5);

        issue(32'h304, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_readable", 32'(mem_readable), 0);
        chk("rst_mid_resp", 32'(resp_valid), 0);
        chk("rst_mid_addr", mem_addr, 0);
        void'(rq.pop_back());
        model_clear();
        mmiss = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_resp", 32'(rq.size()), 0);
        issue(32'h104, 0);
        drain();
        chk("rst_then_miss", 32'(miss_count), 1);

        issue(32'h100, 1);
        issue(32'h104, 1);
        issue(32'h108, 1);
        req_valid = 1'b0;
        drain();
        chk("stream_hits", 32'(miss_count), 1);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 7)) << 10) |
                (32'($urandom_range(0, 255)) << 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, 0);
        end
        drain();
        chk("random_miss_count", 32'(miss_count), 32'(mmiss));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
